// File: rtl/preadd_issue_ctrl_if.sv
// Request, pre-adder and result bus of preadd_issue_ctrl.
// master is the controller's view; slave is the surrounding logic's view.
interface preadd_issue_ctrl_if;
   logic        S_VALID;
   logic        S_READY;
   logic [29:0] S_A;
   logic [24:0] S_D;
   logic [3:0]  S_MODE;
   logic [29:0] A_OUT;
   logic [24:0] D_OUT;
   logic [3:0]  INMODE_0TO3;
   logic        CEA1;
   logic        CEA2;
   logic        CED;
   logic        CEAD;
   logic [24:0] A_MULT_IN;
   logic        M_VALID;
   logic        M_READY;
   logic [24:0] M_DATA;

   modport master (
      input  S_VALID, S_A, S_D, S_MODE, A_MULT_IN, M_READY,
      output S_READY, A_OUT, D_OUT, INMODE_0TO3, CEA1, CEA2, CED, CEAD,
             M_VALID, M_DATA
   );

   modport slave (
      output S_VALID, S_A, S_D, S_MODE, A_MULT_IN, M_READY,
      input  S_READY, A_OUT, D_OUT, INMODE_0TO3, CEA1, CEA2, CED, CEAD,
             M_VALID, M_DATA
   );
endinterface

// File: rtl/preadd_issue_ctrl.sv
// Issue controller for the DSP48E1 A/D pre-adder: latency tracking, capture and result FIFO.
// Optional PREADD_ISSUE_STATS_EN adds ISSUE_CNT/STALL_CNT handshake and stall counters.
module preadd_issue_ctrl #(
   parameter int    AREG       = 2,
   parameter int    ADREG      = 1,
   parameter int    DREG       = 1,
   parameter string USE_DPORT  = "FALSE",
   parameter int    FIFO_DEPTH = 4
) (
   input  logic CLK,
   input  logic RSTN,
   preadd_issue_ctrl_if.master bus
`ifdef PREADD_ISSUE_STATS_EN
   ,
   output logic [31:0] ISSUE_CNT,
   output logic [31:0] STALL_CNT
`endif
);

   localparam int AW       = $clog2(FIFO_DEPTH);
   localparam int CW       = AW + 1;
   localparam int LAT_BASE = (AREG == 0 && ADREG == 0) ? DREG : AREG + ADREG;
   localparam int LAT_M0   = (USE_DPORT == "TRUE") ? LAT_BASE : AREG;
   localparam int LAT_M1   = (USE_DPORT == "TRUE") ? ((AREG == 2) ? AREG + ADREG - 1 : LAT_BASE)
                                                   : ((AREG == 2) ? AREG - 1 : AREG);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t          r_state;
   logic [3:0]      r_curMode;
   logic            r_ce;
   logic [3:0]      r_track;
   logic [CW-1:0]   r_inflight;
   logic [CW-1:0]   r_count;
   logic [AW-1:0]   r_wrPtr;
   logic [AW-1:0]   r_rdPtr;
   logic [24:0]     r_mem [FIFO_DEPTH];
   logic [29:0]     r_aHold;
   logic [24:0]     r_dHold;

   logic [1:0]      w_lat;
   logic            w_modeMatch;
   logic            w_notEmpty;
   logic            w_pop;
   logic [CW-1:0]   w_used;
   logic            w_ready;
   logic            w_issue;
   logic [3:0]      w_trackNow;
   logic            w_capture;

   assign w_lat       = r_curMode[0] ? 2'(LAT_M1) : 2'(LAT_M0);
   assign w_modeMatch = (bus.S_MODE == r_curMode);
   assign w_notEmpty  = (r_count != '0);
   assign w_pop       = w_notEmpty && bus.M_READY;
   // A slot popped this cycle is already free, so streaming at L=3 needs no extra entry.
   assign w_used      = r_inflight + r_count - CW'(w_pop);
   assign w_ready     = (r_state == RUN) && (w_used < CW'(FIFO_DEPTH)) && w_modeMatch;
   assign w_issue     = bus.S_VALID && w_ready;
   assign w_trackNow  = r_track | (w_issue ? (4'b0001 << w_lat) : 4'b0000);
   assign w_capture   = w_trackNow[0];

   assign bus.S_READY     = w_ready;
   assign bus.A_OUT       = w_issue ? bus.S_A : r_aHold;
   assign bus.D_OUT       = w_issue ? bus.S_D : r_dHold;
   assign bus.INMODE_0TO3 = r_curMode;
   assign bus.CEA1        = r_ce;
   assign bus.CEA2        = r_ce;
   assign bus.CED         = r_ce;
   assign bus.CEAD        = r_ce;
   assign bus.M_VALID     = w_notEmpty;
   assign bus.M_DATA      = w_notEmpty ? r_mem[r_rdPtr] : '0;

   // Mode only reloads with an empty tracker, so in-flight ops never see a latency change.
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_state   <= IDLE;
         r_curMode <= '0;
         r_ce      <= 1'b0;
      end else begin
         case (r_state)
            IDLE: begin
               if (bus.S_VALID) begin
                  r_curMode <= bus.S_MODE;
                  r_state   <= RUN;
                  r_ce      <= 1'b1;
               end
            end
            RUN: begin
               if (bus.S_VALID && !w_modeMatch) begin
                  r_state <= DRAIN;
               end else if (!bus.S_VALID && r_track == '0) begin
                  r_state <= IDLE;
                  r_ce    <= 1'b0;
               end
            end
            DRAIN: begin
               if (r_track == '0) begin
                  r_state <= RUN;
                  if (bus.S_VALID) begin
                     r_curMode <= bus.S_MODE;
                  end
               end
            end
            default: begin
               r_state <= IDLE;
               r_ce    <= 1'b0;
            end
         endcase
      end
   end

   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         r_track    <= '0;
         r_inflight <= '0;
         r_count    <= '0;
         r_wrPtr    <= '0;
         r_rdPtr    <= '0;
         r_aHold    <= '0;
         r_dHold    <= '0;
      end else begin
         r_track    <= w_trackNow >> 1;
         r_inflight <= r_inflight + CW'(w_issue) - CW'(w_capture);
         r_count    <= r_count + CW'(w_capture) - CW'(w_pop);
         if (w_capture) begin
            r_wrPtr <= r_wrPtr + AW'(1);
         end
         if (w_pop) begin
            r_rdPtr <= r_rdPtr + AW'(1);
         end
         if (w_issue) begin
            r_aHold <= bus.S_A;
            r_dHold <= bus.S_D;
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (w_capture) begin
         r_mem[r_wrPtr] <= bus.A_MULT_IN;
      end
   end

`ifdef PREADD_ISSUE_STATS_EN
   always_ff @(posedge CLK or negedge RSTN) begin
      if (!RSTN) begin
         ISSUE_CNT <= '0;
         STALL_CNT <= '0;
      end else begin
         ISSUE_CNT <= ISSUE_CNT + 32'(w_issue);
         STALL_CNT <= STALL_CNT + 32'(bus.S_VALID && !w_ready);
      end
   end
`endif

endmodule

// File: tb/tb_preadd_issue_ctrl.sv
// Bench for preadd_issue_ctrl: a DSP-port instance (L=3/2) and a zero-latency instance,
// each fed by a behavioural pre-adder and checked against a result scoreboard.
module tb_preadd_issue_ctrl;

   logic clk = 1'b0;
   logic rstN;
   int   compared;
   int   mismatched;
   int   popA;
   logic [24:0] sbA [$];
   logic [24:0] sbZ [$];
   logic [24:0] expA;
   logic [24:0] expZ;

   always #5 clk = ~clk;

   preadd_issue_ctrl_if ifA ();
   preadd_issue_ctrl_if ifZ ();

`ifdef PREADD_ISSUE_STATS_EN
   logic [31:0] issueCntA, stallCntA, issueCntZ, stallCntZ;
`endif

   preadd_issue_ctrl #(.AREG(2), .ADREG(1), .DREG(1), .USE_DPORT("TRUE"), .FIFO_DEPTH(4)) dutA (
      .CLK(clk), .RSTN(rstN), .bus(ifA.master)
`ifdef PREADD_ISSUE_STATS_EN
      , .ISSUE_CNT(issueCntA), .STALL_CNT(stallCntA)
`endif
   );

   preadd_issue_ctrl #(.AREG(0), .ADREG(0), .DREG(0), .USE_DPORT("FALSE"), .FIFO_DEPTH(4)) dutZ (
      .CLK(clk), .RSTN(rstN), .bus(ifZ.master)
`ifdef PREADD_ISSUE_STATS_EN
      , .ISSUE_CNT(issueCntZ), .STALL_CNT(stallCntZ)
`endif
   );

   function automatic logic [24:0] preadd(input logic [3:0] m, input logic [29:0] a, input logic [24:0] d);
      logic [24:0] av;
      logic [24:0] dv;
      av = m[1] ? 25'd0 : a[24:0];
      dv = m[2] ? d : 25'd0;
      return m[3] ? (dv - av) : (dv + av);
   endfunction

   // Pre-adder models: three CE-gated stages with the INMODE[0] A1 tap one stage shorter, and a pure combinational one.
   logic [24:0] pA1, pA2, pA3;
   wire  [24:0] adA = preadd(ifA.INMODE_0TO3, ifA.A_OUT, ifA.D_OUT);

   always @(posedge clk) begin
      if (ifA.CEAD) begin
         pA1 <= adA;
         pA2 <= pA1;
         pA3 <= pA2;
      end
   end

   assign ifA.A_MULT_IN = ifA.INMODE_0TO3[0] ? pA2 : pA3;
   assign ifZ.A_MULT_IN = preadd(ifZ.INMODE_0TO3, ifZ.A_OUT, ifZ.D_OUT);

   task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      compared++;
      assert (observed === expected) else begin
         mismatched++;
         $error("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Scoreboards: push the expected pre-adder result on each request handshake, pop on each result handshake.
   always @(negedge clk) begin
      if (rstN) begin
         if (ifA.M_VALID && ifA.M_READY) begin
            checkOutput("sbA_nonempty", 32'(sbA.size() != 0), 32'd1);
            if (sbA.size() != 0) begin
               expA = sbA.pop_front();
               checkOutput("sbA_data", 32'(ifA.M_DATA), 32'(expA));
               popA++;
            end
         end
         if (ifA.S_VALID && ifA.S_READY) begin
            sbA.push_back(preadd(ifA.S_MODE, ifA.S_A, ifA.S_D));
         end
      end
   end

   always @(negedge clk) begin
      if (rstN) begin
         if (ifZ.M_VALID && ifZ.M_READY) begin
            checkOutput("sbZ_nonempty", 32'(sbZ.size() != 0), 32'd1);
            if (sbZ.size() != 0) begin
               expZ = sbZ.pop_front();
               checkOutput("sbZ_data", 32'(ifZ.M_DATA), 32'(expZ));
            end
         end
         if (ifZ.S_VALID && ifZ.S_READY) begin
            sbZ.push_back(preadd(ifZ.S_MODE, ifZ.S_A, ifZ.S_D));
         end
      end
   end

   // Offers random ops on ifA until n are accepted or the cycle budget runs out.
   task automatic applyStimulus(input int n, input logic [3:0] mode, input int budget,
                                output int sent, output int stalls);
      bit took;
      sent   = 0;
      stalls = 0;
      ifA.S_MODE  = mode;
      ifA.S_A     = 30'($urandom());
      ifA.S_D     = 25'($urandom());
      ifA.S_VALID = 1'b1;
      for (int c = 0; c < budget && sent < n; c++) begin
         @(negedge clk);
         took = ifA.S_READY;
         if (took) sent++;
         else stalls++;
         @(posedge clk);
         #1;
         if (took) begin
            ifA.S_A = 30'($urandom());
            ifA.S_D = 25'($urandom());
         end
      end
      ifA.S_VALID = 1'b0;
   endtask

   initial begin
      #100000;
      $display("[TB] FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int sent;
      int stalls;
      int stale;
      int popBefore;
      logic [29:0] a;
      logic [24:0] d0;

      compared   = 0;
      mismatched = 0;
      popA       = 0;
      ifA.S_VALID = 1'b0; ifA.S_A = '0; ifA.S_D = '0; ifA.S_MODE = '0; ifA.M_READY = 1'b1;
      ifZ.S_VALID = 1'b0; ifZ.S_A = '0; ifZ.S_D = '0; ifZ.S_MODE = '0; ifZ.M_READY = 1'b1;
      rstN = 1'b0;

      repeat (2) @(posedge clk);
      @(negedge clk);
      checkOutput("rst_s_ready", 32'(ifA.S_READY), 32'd0);
      checkOutput("rst_m_valid", 32'(ifA.M_VALID), 32'd0);
      checkOutput("rst_m_data", 32'(ifA.M_DATA), 32'd0);
      checkOutput("rst_a_out", 32'(ifA.A_OUT), 32'd0);
      checkOutput("rst_d_out", 32'(ifA.D_OUT), 32'd0);
      checkOutput("rst_inmode", 32'(ifA.INMODE_0TO3), 32'd0);
      checkOutput("rst_ce", 32'({ifA.CEA1, ifA.CEA2, ifA.CED, ifA.CEAD}), 32'd0);
      @(posedge clk);
      #1 rstN = 1'b1;

      // Single op, D+A, L=3: visible four cycles after the issue cycle.
      ifA.S_A = 30'h5; ifA.S_D = 25'h3; ifA.S_MODE = 4'b0100; ifA.S_VALID = 1'b1;
      @(negedge clk);
      checkOutput("t1_idle_ready", 32'(ifA.S_READY), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("t1_run_ready", 32'(ifA.S_READY), 32'd1);
      checkOutput("t1_ce", 32'({ifA.CEA1, ifA.CEA2, ifA.CED, ifA.CEAD}), 32'hF);
      checkOutput("t1_a_out", 32'(ifA.A_OUT), 32'h5);
      @(posedge clk); #1;
      ifA.S_VALID = 1'b0;
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         checkOutput("t1_early_valid", 32'(ifA.M_VALID), 32'd0);
      end
      @(negedge clk);
      checkOutput("t1_valid", 32'(ifA.M_VALID), 32'd1);
      checkOutput("t1_data", 32'(ifA.M_DATA), 32'h8);
      repeat (4) @(posedge clk); #1;

      // Back-to-back D-A stream: only the IDLE->RUN cycle may stall.
      applyStimulus(16, 4'b1100, 40, sent, stalls);
      checkOutput("t2_sent", 32'(sent), 32'd16);
      checkOutput("t2_stalls", 32'(stalls), 32'd1);
      repeat (8) @(posedge clk); #1;
      checkOutput("t2_sb_empty", 32'(sbA.size()), 32'd0);

      // Mode switch 0000 -> 0001 with no gap: four stalled cycles, then L=2.
      applyStimulus(4, 4'b0000, 20, sent, stalls);
      checkOutput("t3_sent", 32'(sent), 32'd4);
      a = 30'($urandom());
      ifA.S_A = a; ifA.S_D = 25'($urandom()); ifA.S_MODE = 4'b0001; ifA.S_VALID = 1'b1;
      for (int k = 0; k < 4; k++) begin
         @(negedge clk);
         checkOutput("t3_drain_ready", 32'(ifA.S_READY), 32'd0);
         @(posedge clk); #1;
      end
      @(negedge clk);
      checkOutput("t3_reload_ready", 32'(ifA.S_READY), 32'd1);
      @(posedge clk); #1;
      ifA.S_VALID = 1'b0;
      for (int k = 0; k < 2; k++) begin
         @(negedge clk);
         checkOutput("t3_early_valid", 32'(ifA.M_VALID), 32'd0);
      end
      @(negedge clk);
      checkOutput("t3_valid", 32'(ifA.M_VALID), 32'd1);
      checkOutput("t3_data", 32'(ifA.M_DATA), 32'(a[24:0]));
      repeat (4) @(posedge clk); #1;
      checkOutput("t3_sb_empty", 32'(sbA.size()), 32'd0);

      // Back-pressure: credits stop the stream at FIFO_DEPTH, head held stable.
      ifA.M_READY = 1'b0;
      applyStimulus(8, 4'b0100, 20, sent, stalls);
      checkOutput("t4_accepted", 32'(sent), 32'd4);
      @(negedge clk);
      checkOutput("t4_ready_low", 32'(ifA.S_READY), 32'd0);
      checkOutput("t4_valid_held", 32'(ifA.M_VALID), 32'd1);
      d0 = sbA[0];
      checkOutput("t4_head", 32'(ifA.M_DATA), 32'(d0));
      @(negedge clk);
      checkOutput("t4_head_stable", 32'(ifA.M_DATA), 32'(d0));
      @(posedge clk); #1;
      ifA.M_READY = 1'b1;
      applyStimulus(4, 4'b0100, 30, sent, stalls);
      checkOutput("t4_rest", 32'(sent), 32'd4);
      repeat (8) @(posedge clk); #1;
      checkOutput("t4_sb_empty", 32'(sbA.size()), 32'd0);

      // Asynchronous reset with three ops in flight.
      applyStimulus(3, 4'b0100, 10, sent, stalls);
      checkOutput("t5_sent", 32'(sent), 32'd3);
      #2 rstN = 1'b0;
      #1;
      checkOutput("t5_s_ready", 32'(ifA.S_READY), 32'd0);
      checkOutput("t5_m_valid", 32'(ifA.M_VALID), 32'd0);
      checkOutput("t5_a_out", 32'(ifA.A_OUT), 32'd0);
      checkOutput("t5_ce", 32'({ifA.CEA1, ifA.CEA2, ifA.CED, ifA.CEAD}), 32'd0);
      sbA.delete();
      repeat (2) @(posedge clk);
      #1 rstN = 1'b1;
      stale = 0;
      for (int k = 0; k < 8; k++) begin
         @(negedge clk);
         if (ifA.M_VALID) stale++;
      end
      checkOutput("t5_stale_valid", 32'(stale), 32'd0);
      @(posedge clk); #1;
      popBefore = popA;
      applyStimulus(1, 4'b0100, 5, sent, stalls);
      repeat (8) @(posedge clk); #1;
      checkOutput("t5_new_result", 32'(popA - popBefore), 32'd1);

      // Zero-latency instance: captured in the issue cycle, valid the next.
      a = 30'($urandom());
      ifZ.S_A = a; ifZ.S_D = 25'($urandom()); ifZ.S_MODE = 4'b0000; ifZ.S_VALID = 1'b1;
      @(negedge clk);
      checkOutput("t6_idle_ready", 32'(ifZ.S_READY), 32'd0);
      @(posedge clk); #1;
      @(negedge clk);
      checkOutput("t6_ready", 32'(ifZ.S_READY), 32'd1);
      checkOutput("t6_no_valid_yet", 32'(ifZ.M_VALID), 32'd0);
      @(posedge clk); #1;
      ifZ.S_VALID = 1'b0;
      @(negedge clk);
      checkOutput("t6_valid", 32'(ifZ.M_VALID), 32'd1);
      checkOutput("t6_data", 32'(ifZ.M_DATA), 32'(a[24:0]));
      repeat (3) @(posedge clk); #1;
      checkOutput("t6_sb_empty", 32'(sbZ.size()), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule
